// File: rtl/wbs_pwm_led_if.sv
// Wishbone B4 pipelined bus bundle for the PWM LED slave.
// Signal names keep the slave-side _i/_o suffixes so both ends read alike.
interface wbs_pwm_led_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [3:0]  wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_stall_o;
  logic        wb_ack_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_dat_o, wb_stall_o, wb_ack_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_dat_o, wb_stall_o, wb_ack_o
  );
endinterface

// File: rtl/wbs_pwm_led.sv
// Wishbone pipelined slave with CHANNELS PWM LED outputs: prescaler, global
// enable/invert, shadow duty registers reloaded into active duties at wrap.
module wbs_pwm_led #(
  parameter int CHANNELS = 3,
  parameter int WIDTH    = 8
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  wbs_pwm_led_if.slave        bus,
  output logic [CHANNELS-1:0] led_o
);

  localparam logic [WIDTH-1:0] CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

  logic                w_xfer;
  logic                w_wr;
  logic [31:0]         w_rdata;
  logic [31:0]         w_wmerge;
  logic                w_en_set;
  logic                w_tick;
  logic                w_wrap;
  logic [CHANNELS-1:0] w_pwm;

  logic                r_ack;
  logic [31:0]         r_dat;
  logic                r_enable;
  logic                r_invert;
  logic [15:0]         r_presc;
  logic [15:0]         r_pcnt;
  logic [WIDTH-1:0]    r_cnt;
  logic [WIDTH-1:0]    r_shadow [CHANNELS];
  logic [WIDTH-1:0]    r_active [CHANNELS];
  logic [CHANNELS-1:0] r_led;

  function automatic logic [31:0] f_lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

  assign w_xfer = bus.wb_cyc_i && bus.wb_stb_i;
  assign w_wr   = w_xfer && bus.wb_we_i;

  // Read mux; also the "old value" side of the byte-lane write merge.
  always_comb begin
    w_rdata = 32'd0;
    case (bus.wb_adr_i)
      4'd0:    w_rdata = {30'd0, r_invert, r_enable};
      4'd1:    w_rdata = {16'd0, r_presc};
      default: begin
        for (int n = 0; n < CHANNELS; n++) begin
          w_rdata = (bus.wb_adr_i == 4'(n + 2)) ? 32'(r_shadow[n]) : w_rdata;
        end
      end
    endcase
  end

  assign w_wmerge = f_lane_merge(w_rdata, bus.wb_dat_i, bus.wb_sel_i);
  assign w_en_set = w_wr && (bus.wb_adr_i == 4'd0) && w_wmerge[0] && !r_enable;
  assign w_tick   = r_enable && (r_pcnt >= r_presc);
  assign w_wrap   = w_tick && (r_cnt == CNT_LAST);

  // Per-channel compare against the active (not shadow) duty.
  always_comb begin
    w_pwm = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      w_pwm[n] = r_enable && (r_cnt < r_active[n]);
    end
  end

  // Bus side: ack, read data and the programmable registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_ack    <= 1'b0;
      r_dat    <= 32'd0;
      r_enable <= 1'b0;
      r_invert <= 1'b0;
      r_presc  <= 16'd0;
      for (int n = 0; n < CHANNELS; n++) begin
        r_shadow[n] <= '0;
      end
    end else begin
      r_ack <= w_xfer;
      r_dat <= w_xfer ? w_rdata : 32'd0;
      if (w_wr) begin
        case (bus.wb_adr_i)
          4'd0: begin
            r_enable <= w_wmerge[0];
            r_invert <= w_wmerge[1];
          end
          4'd1:    r_presc <= w_wmerge[15:0];
          default: begin
            for (int n = 0; n < CHANNELS; n++) begin
              if (bus.wb_adr_i == 4'(n + 2)) begin
                r_shadow[n] <= w_wmerge[WIDTH-1:0];
              end
            end
          end
        endcase
      end
    end
  end

  // PWM engine; the active duty reload also fires when enable is first set
  // so the first enabled period already uses the programmed duty.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_pcnt <= 16'd0;
      r_cnt  <= '0;
      r_led  <= '0;
      for (int n = 0; n < CHANNELS; n++) begin
        r_active[n] <= '0;
      end
    end else begin
      if (!r_enable) begin
        r_pcnt <= 16'd0;
        r_cnt  <= '0;
      end else if (w_tick) begin
        r_pcnt <= 16'd0;
        r_cnt  <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
      end else begin
        r_pcnt <= r_pcnt + 16'd1;
      end
      for (int n = 0; n < CHANNELS; n++) begin
        if (w_en_set || w_wrap) begin
          r_active[n] <= r_shadow[n];
        end
      end
      r_led <= w_pwm ^ {CHANNELS{r_invert}};
    end
  end

  assign bus.wb_ack_o   = r_ack;
  assign bus.wb_dat_o   = r_dat;
  assign bus.wb_stall_o = 1'b0;
  assign led_o          = r_led;

endmodule

// File: tb/tb_wbs_pwm_led.sv
// Directed bench for wbs_pwm_led: register table vectors plus PWM waveform,
// burst, cyc-drop and mid-cycle reset sequences.
module tb_wbs_pwm_led;

  logic       clk;
  logic       rst_n;
  logic [2:0] led;
  int         n_checks;
  int         n_errors;
  int         cyc_cnt;

  wbs_pwm_led_if bus ();

  wbs_pwm_led #(.CHANNELS(3), .WIDTH(8)) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .bus      (bus),
    .led_o    (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    logic        we;
    logic [3:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single transfer from a post-edge sample point; checks ack timing.
  task automatic xfer(input logic we, input logic [3:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rd);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = we;
    bus.wb_adr_i = adr;
    bus.wb_dat_i = dat;
    bus.wb_sel_i = sel;
    step();
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    chk("ack_high", 32'(bus.wb_ack_o), 32'd1);
    chk("stall", 32'(bus.wb_stall_o), 32'd0);
    rd = bus.wb_dat_o;
    step();
    chk("ack_single", 32'(bus.wb_ack_o), 32'd0);
  endtask

  task automatic wr(input logic [3:0] adr, input logic [31:0] dat);
    logic [31:0] rd;
    xfer(1'b1, adr, dat, 4'hF, rd);
  endtask

  task automatic wait_led0(input logic v, input int bound, output int at);
    int i;
    for (i = 0; i < bound; i++) begin
      if (led[0] == v) break;
      step();
    end
    if (i == bound) chk("led0_timeout", 32'd0, 32'd1);
    at = cyc_cnt;
  endtask

  task automatic count_high(input int ch, input int len, output int hi);
    hi = 0;
    for (int i = 0; i < len; i++) begin
      if (led[ch]) hi++;
      step();
    end
  endtask

  initial begin
    logic [31:0] rd;
    int hi;
    int t_f;
    int t_r;
    int t_f2;
    vec_t burst [8];

    n_checks = 0;
    n_errors = 0;
    cyc_cnt  = 0;
    rst_n    = 1'b0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    bus.wb_adr_i = 4'd0;
    bus.wb_sel_i = 4'h0;
    bus.wb_dat_i = 32'd0;

    vecs[0]  = '{1'b0, 4'd0,  32'h0,        4'hF, 32'h0};
    vecs[1]  = '{1'b0, 4'd1,  32'h0,        4'hF, 32'h0};
    vecs[2]  = '{1'b0, 4'd2,  32'h0,        4'hF, 32'h0};
    vecs[3]  = '{1'b0, 4'd15, 32'h0,        4'hF, 32'h0};
    vecs[4]  = '{1'b1, 4'd2,  32'h12345678, 4'h1, 32'h0};
    vecs[5]  = '{1'b0, 4'd2,  32'h0,        4'hF, 32'h78};
    vecs[6]  = '{1'b1, 4'd2,  32'h0000FF00, 4'h2, 32'h0};
    vecs[7]  = '{1'b0, 4'd2,  32'h0,        4'hF, 32'h78};
    vecs[8]  = '{1'b1, 4'd1,  32'hABCD1234, 4'hF, 32'h0};
    vecs[9]  = '{1'b0, 4'd1,  32'h0,        4'hF, 32'h1234};
    vecs[10] = '{1'b1, 4'd1,  32'h00005600, 4'h2, 32'h0};
    vecs[11] = '{1'b0, 4'd1,  32'h0,        4'hF, 32'h5634};
    vecs[12] = '{1'b1, 4'd0,  32'h00000003, 4'h0, 32'h0};
    vecs[13] = '{1'b0, 4'd0,  32'h0,        4'hF, 32'h0};
    vecs[14] = '{1'b1, 4'd5,  32'hFFFFFFFF, 4'hF, 32'h0};
    vecs[15] = '{1'b0, 4'd5,  32'h0,        4'hF, 32'h0};

    repeat (3) step();
    chk("rst_ack", 32'(bus.wb_ack_o), 32'd0);
    chk("rst_dat", bus.wb_dat_o, 32'd0);
    chk("rst_led", 32'(led), 32'd0);
    rst_n = 1'b1;
    repeat (2) step();

    for (int i = 0; i < 16; i++) begin
      xfer(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, rd);
      if (!vecs[i].we) chk($sformatf("vec%0d_rd", i), rd, vecs[i].exp);
    end
    chk("led_idle", 32'(led), 32'd0);

    // P=0, duties 64/0/255: 255-clock period.
    wr(4'd1, 32'd0);
    wr(4'd2, 32'd64);
    wr(4'd3, 32'd0);
    wr(4'd4, 32'd255);
    wr(4'd0, 32'd1);
    count_high(0, 255, hi); chk("ch0_high64", 32'(hi), 32'd64);
    count_high(1, 255, hi); chk("ch1_off", 32'(hi), 32'd0);
    count_high(2, 255, hi); chk("ch2_on", 32'(hi), 32'd255);

    // Duty change mid-period applies only after the next wrap.
    wait_led0(1'b1, 600, t_r);
    wait_led0(1'b0, 600, t_f);
    wr(4'd2, 32'd128);
    wait_led0(1'b1, 600, t_r);
    chk("mid_low_run", 32'(t_r - t_f), 32'd191);
    wait_led0(1'b0, 600, t_f2);
    chk("new_high_run", 32'(t_f2 - t_r), 32'd128);

    // P=3, DUTY0=1: 4 high clocks per 1020, then inverted, then disabled.
    wr(4'd0, 32'd0);
    wr(4'd1, 32'd3);
    wr(4'd2, 32'd1);
    wr(4'd0, 32'd1);
    count_high(0, 1020, hi); chk("p3_high4", 32'(hi), 32'd4);
    wr(4'd0, 32'd3);
    count_high(0, 1020, hi); chk("p3_inv", 32'(hi), 32'd1016);
    wr(4'd0, 32'd2);
    chk("dis_inv_led", 32'(led), 32'd7);

    // Back-to-back 4 writes then 4 reads.
    burst[0] = '{1'b1, 4'd2, 32'h11,   4'hF, 32'h0};
    burst[1] = '{1'b1, 4'd3, 32'h22,   4'hF, 32'h0};
    burst[2] = '{1'b1, 4'd4, 32'h33,   4'hF, 32'h0};
    burst[3] = '{1'b1, 4'd1, 32'h4444, 4'hF, 32'h0};
    burst[4] = '{1'b0, 4'd2, 32'h0,    4'hF, 32'h11};
    burst[5] = '{1'b0, 4'd3, 32'h0,    4'hF, 32'h22};
    burst[6] = '{1'b0, 4'd4, 32'h0,    4'hF, 32'h33};
    burst[7] = '{1'b0, 4'd1, 32'h0,    4'hF, 32'h4444};
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        chk($sformatf("burst%0d_ack", i - 1), 32'(bus.wb_ack_o), 32'd1);
        chk("burst_stall", 32'(bus.wb_stall_o), 32'd0);
        if (!burst[i-1].we) chk($sformatf("burst%0d_rd", i - 1), bus.wb_dat_o, burst[i-1].exp);
      end
      if (i < 8) begin
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = burst[i].we;
        bus.wb_adr_i = burst[i].adr;
        bus.wb_dat_i = burst[i].dat;
        bus.wb_sel_i = burst[i].sel;
        step();
      end else begin
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
      end
    end
    step();
    chk("burst_end_ack", 32'(bus.wb_ack_o), 32'd0);

    // cyc dropped mid-burst: issued ack completes, strobe without cyc ignored.
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = 1'b0;
    bus.wb_adr_i = 4'd0;
    step();
    bus.wb_cyc_i = 1'b0;
    bus.wb_we_i  = 1'b1;
    bus.wb_dat_i = 32'd1;
    bus.wb_sel_i = 4'hF;
    chk("cyc_drop_prev_ack", 32'(bus.wb_ack_o), 32'd1);
    step();
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    chk("cyc_drop_no_ack", 32'(bus.wb_ack_o), 32'd0);
    xfer(1'b0, 4'd0, 32'd0, 4'hF, rd);
    chk("cyc_drop_no_write", rd, 32'd2);

    // Reset mid-cycle while an ack is showing.
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_adr_i = 4'd1;
    step();
    chk("pre_rst_ack", 32'(bus.wb_ack_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ack", 32'(bus.wb_ack_o), 32'd0);
    chk("async_rst_dat", bus.wb_dat_o, 32'd0);
    chk("async_rst_led", 32'(led), 32'd0);
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    xfer(1'b0, 4'd1, 32'd0, 4'hF, rd);
    chk("post_rst_presc", rd, 32'd0);
    xfer(1'b0, 4'd2, 32'd0, 4'hF, rd);
    chk("post_rst_duty0", rd, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
